tt_um_xxd_reverse_theshteves: RTL and testbench

Byte-stream reverse hex dumper (xxd -r) for the xxd Tiny Tapeout tile.
- Accepts ASCII characters on ui_in, parses either full xxd line format or plain (-p) hex, and packs digit pairs into bytes.
- Emits bytes through a small output FIFO with a valid/ready handshake on uo_out/uio.
- Is the decoder counterpart of the tile's byte-delay/dump path: its output stream can be checked against the bytes originally dumped.

---
 rtl/xxd_pkg.sv | 42 ++++
 rtl/xxd_byte_fifo.sv | 62 ++++++
 rtl/tt_um_xxd_reverse_theshteves.sv | 210 +++++++++++++++++++++
 tb/tb_tt_um_xxd_reverse_theshteves.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xxd_pkg.sv
// Shared definitions for the xxd reverse (hex-to-byte) decoder.
//   - ASCII character constants used by the classifier
//   - parser state enumeration
//   - hex_nibble(): maps an ASCII character to {is_hex, nibble}
package xxd_pkg;

  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  // Parser position within an xxd line. In plain mode ADDR and ASCII
  // behave exactly like HEX.
  typedef enum logic [1:0] {
    ADDR  = 2'd0,
    HEX   = 2'd1,
    LO    = 2'd2,
    ASCII = 2'd3
  } parse_state_t;

  // Returns {is_hex, nibble}; nibble is 4'h0 when the char is not a hex digit.
  function automatic logic [4:0] hex_nibble(input logic [7:0] ch);
    logic [7:0] diff;
    logic       valid;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      diff  = ch - 8'h30;
      valid = 1'b1;
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      diff  = ch - 8'h37;
      valid = 1'b1;
    end else if (ch >= 8'h61 && ch <= 8'h66) begin
      diff  = ch - 8'h57;
      valid = 1'b1;
    end else begin
      diff  = 8'h00;
      valid = 1'b0;
    end
    return {valid, diff[3:0]};
  endfunction

endpackage

// File: rtl/xxd_byte_fifo.sv
// Small byte FIFO holding decoded output bytes.
//   clk, rst_n   : clock, synchronous active-low reset
//   push, push_data : write one byte (caller guarantees not full)
//   pop          : remove head byte; ignored when empty
//   head         : byte at the head (undefined content when empty)
//   count        : number of stored bytes, 0..DEPTH
//   empty        : count == 0
module xxd_byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_ok_s;

  assign empty    = (count_r == CW'(0));
  assign pop_ok_s = pop & ~empty;
  assign head     = mem_r[rd_ptr_r];
  assign count    = count_r;

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/tt_um_xxd_reverse_theshteves.sv
// Reverse hex dumper (xxd -r) for the xxd Tiny Tapeout tile.
// Parses ASCII characters in xxd line format or plain hex, packs digit
// pairs into bytes and queues them in a small output FIFO.
//   clk, rst_n : clock, synchronous active-low reset
//   ena        : power indicator (unused)
//   ui_in      : ASCII input character
//   uo_out     : FIFO head byte, 0x00 when empty
//   uio_in     : [0] in_valid, [1] plain_mode, [5] out_ready
//   uio_out    : [4] out_valid, [6] in_ready, [7] error (sticky)
//   uio_oe     : constant 8'b1101_0000
module tt_um_xxd_reverse_theshteves
  import xxd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          in_valid_s;
  logic          plain_in_s;
  logic          out_ready_s;
  logic          in_ready_s;
  logic          accept_s;

  // One-entry char buffer and parser state
  logic [7:0]    char_r;
  logic          plain_r;
  logic          buf_valid_r;
  parse_state_t  state_r;
  parse_state_t  state_next_s;
  logic [3:0]    hi_r;
  logic [3:0]    hi_next_s;
  logic          prev_space_r;
  logic          prev_space_next_s;
  logic          error_r;
  logic          error_next_s;

  // Classifier outputs for the buffered char
  logic [4:0]    hex_s;
  logic          is_hex_s;
  logic          is_sp_s;
  logic          is_nl_s;
  logic          is_colon_s;

  logic          push_s;
  logic [7:0]    push_data_s;
  logic [7:0]    head_s;
  logic [CW-1:0] fifo_count_s;
  logic          fifo_empty_s;

  assign in_valid_s  = uio_in[0];
  assign plain_in_s  = uio_in[1];
  assign out_ready_s = uio_in[5];

  // Leaving room for two bytes means the char already in flight always
  // finds a free slot, so the FIFO can never overflow.
  assign in_ready_s = (fifo_count_s <= CW'(FIFO_DEPTH - 2));
  assign accept_s   = in_valid_s & in_ready_s;

  assign hex_s      = hex_nibble(char_r);
  assign is_hex_s   = hex_s[4];
  assign is_sp_s    = (char_r == CH_SPACE) || (char_r == CH_TAB) || (char_r == CH_CR);
  assign is_nl_s    = (char_r == CH_LF);
  assign is_colon_s = (char_r == CH_COLON);

  assign push_data_s = {hi_r, hex_s[3:0]};

  // Char buffer and parser registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      char_r       <= 8'h00;
      plain_r      <= 1'b0;
      buf_valid_r  <= 1'b0;
      state_r      <= ADDR;
      hi_r         <= 4'h0;
      prev_space_r <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        char_r  <= ui_in;
        plain_r <= plain_in_s;
      end
      buf_valid_r  <= accept_s;
      state_r      <= state_next_s;
      hi_r         <= hi_next_s;
      prev_space_r <= prev_space_next_s;
      error_r      <= error_next_s;
    end
  end

  // Parser next state: consumes the buffered char, if any.
  always_comb begin
    state_next_s      = state_r;
    hi_next_s         = hi_r;
    prev_space_next_s = prev_space_r;
    error_next_s      = error_r;
    push_s            = 1'b0;
    if (buf_valid_r) begin
      // prev_space only survives a single space seen in the HEX column
      prev_space_next_s = 1'b0;
      if (plain_r) begin
        case (state_r)
          LO: begin
            if (is_hex_s) begin
              push_s       = 1'b1;
              state_next_s = HEX;
            end else if (is_sp_s || is_nl_s) begin
              state_next_s = LO;
            end else begin
              error_next_s = 1'b1;
              state_next_s = HEX;
            end
          end
          default: begin
            if (is_hex_s) begin
              hi_next_s    = hex_s[3:0];
              state_next_s = LO;
            end else if (is_sp_s || is_nl_s) begin
              state_next_s = state_r;
            end else begin
              error_next_s = 1'b1;
            end
          end
        endcase
      end else begin
        case (state_r)
          ADDR: begin
            if (is_colon_s) begin
              state_next_s = HEX;
            end else begin
              state_next_s = ADDR;
            end
          end
          HEX: begin
            if (is_hex_s) begin
              hi_next_s    = hex_s[3:0];
              state_next_s = LO;
            end else if (is_sp_s) begin
              // Two consecutive spaces end the hex column
              if (prev_space_r) begin
                state_next_s = ASCII;
              end else begin
                prev_space_next_s = 1'b1;
              end
            end else if (is_nl_s) begin
              state_next_s = ADDR;
            end else begin
              error_next_s = 1'b1;
              state_next_s = ASCII;
            end
          end
          LO: begin
            if (is_hex_s) begin
              push_s       = 1'b1;
              state_next_s = HEX;
            end else if (is_nl_s) begin
              error_next_s = 1'b1;
              state_next_s = ADDR;
            end else begin
              error_next_s = 1'b1;
              state_next_s = ASCII;
            end
          end
          ASCII: begin
            if (is_nl_s) begin
              state_next_s = ADDR;
            end else begin
              state_next_s = ASCII;
            end
          end
          default: begin
            state_next_s = ADDR;
          end
        endcase
      end
    end else begin
      push_s = 1'b0;
    end
  end

  xxd_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (out_ready_s),
    .head      (head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s)
  );

  assign uo_out  = fifo_empty_s ? 8'h00 : head_s;
  assign uio_out = {error_r, in_ready_s, 1'b0, ~fifo_empty_s, 4'b0000};
  assign uio_oe  = 8'b1101_0000;

  logic unused_s;
  assign unused_s = &{1'b0, ena, uio_in[7:6], uio_in[4:2]};

endmodule

// File: tb/tb_tt_um_xxd_reverse_theshteves.sv
// Self-checking bench for tt_um_xxd_reverse_theshteves: directed scenarios
// with literal expectations plus a random phase, all checked every cycle
// against a behavioural xxd -r model.
module tb_tt_um_xxd_reverse_theshteves;

  localparam int DEPTH = 4;
  localparam int M_ADDR = 0, M_HEX = 1, M_LO = 2, M_ASCII = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       in_valid = 1'b0;
  logic       plain = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] uio_in;

  assign uio_in = {2'b00, out_ready, 3'b000, plain, in_valid};

  tt_um_xxd_reverse_theshteves #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // behavioural model
  byte unsigned m_q[$];
  int           m_state = M_ADDR;
  int           m_hi = 0;
  bit           m_prev = 1'b0;
  bit           m_err = 1'b0;
  bit           m_pend = 1'b0;
  byte unsigned m_pc = 8'h00;
  bit           m_pp = 1'b0;
  bit           m_ok = 1'b0;

  byte unsigned dut_popped[$];
  byte unsigned exp_q[$];

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hexval(byte unsigned c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  // Interpret one char by the xxd -r rules; returns byte value or -1.
  function automatic int model_char(byte unsigned c, bit pm);
    int  v = hexval(c);
    bit  ws = (c == 8'h20) || (c == 8'h09) || (c == 8'h0D);
    bit  nl = (c == 8'h0A);
    bit  had_space = m_prev;
    int  out = -1;
    m_prev = 1'b0;
    if (pm) begin
      if (v >= 0) begin
        if (m_state == M_LO) begin out = m_hi * 16 + v; m_state = M_HEX; end
        else begin m_hi = v; m_state = M_LO; end
      end else if (!(ws || nl)) begin
        m_err = 1'b1;
        if (m_state == M_LO) m_state = M_HEX;
      end
    end else if (m_state == M_ADDR) begin
      if (c == 8'h3A) m_state = M_HEX;
    end else if (m_state == M_ASCII) begin
      if (nl) m_state = M_ADDR;
    end else if (m_state == M_LO) begin
      if (v >= 0) begin out = m_hi * 16 + v; m_state = M_HEX; end
      else begin m_err = 1'b1; m_state = nl ? M_ADDR : M_ASCII; end
    end else begin
      if (v >= 0) begin m_hi = v; m_state = M_LO; end
      else if (ws) begin
        if (had_space) m_state = M_ASCII;
        else m_prev = 1'b1;
      end else if (nl) m_state = M_ADDR;
      else begin m_err = 1'b1; m_state = M_ASCII; end
    end
    return out;
  endfunction

  task automatic model_edge();
    bit ready;
    bit do_pop;
    int b;
    if (!rst_n) begin
      m_q.delete();
      m_state = M_ADDR; m_hi = 0; m_prev = 1'b0; m_err = 1'b0; m_pend = 1'b0;
      m_ok = 1'b1;
    end else begin
      ready  = (m_q.size() <= DEPTH - 2);
      do_pop = (m_q.size() > 0) && out_ready;
      b = -1;
      if (m_pend) b = model_char(m_pc, m_pp);
      if (do_pop) void'(m_q.pop_front());
      if (b >= 0) m_q.push_back(8'(b));
      m_pend = in_valid && ready;
      if (m_pend) begin m_pc = ui_in; m_pp = plain; end
    end
  endtask

  task automatic compare();
    if (m_ok) begin
      check("uo_out", uo_out, (m_q.size() > 0) ? m_q[0] : 8'h00);
      check("out_valid", {7'd0, uio_out[4]}, {7'd0, m_q.size() > 0});
      check("in_ready", {7'd0, uio_out[6]}, {7'd0, m_q.size() <= DEPTH - 2});
      check("error", {7'd0, uio_out[7]}, {7'd0, m_err});
      check("uio_out_zero", {3'd0, uio_out[5], uio_out[3:0]}, 8'h00);
      check("uio_oe", uio_oe, 8'hD0);
    end
  endtask

  task automatic step();
    if (uio_out[4] && out_ready) dut_popped.push_back(uo_out);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    dut_popped.delete();
  endtask

  task automatic send_char(byte unsigned c, bit pm);
    bit acc;
    int n = 0;
    ui_in = c; plain = pm; in_valid = 1'b1;
    do begin
      acc = uio_out[6];
      step();
      n++;
    end while (!acc && n < 200);
    in_valid = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_timeout: char %h not accepted within 200 cycles", c);
    end
  endtask

  task automatic send_str(string s, bit pm);
    for (int i = 0; i < s.len(); i++) send_char(s[i], pm);
  endtask

  task automatic check_seq(string name);
    tests++;
    if (dut_popped.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s_len: got %0d bytes, expected %0d", name, dut_popped.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) check(name, dut_popped[i], exp_q[i]);
    end
  endtask

  string hexset = "0123456789abcdefABCDEF";

  initial begin
    // reset state
    do_reset();
    check("rst_out_valid", {7'd0, uio_out[4]}, 8'h00);
    check("rst_in_ready", {7'd0, uio_out[6]}, 8'h01);
    check("rst_error", {7'd0, uio_out[7]}, 8'h00);
    check("rst_uo_out", uo_out, 8'h00);

    // plain "41" with out_ready low, then a single pop
    out_ready = 1'b0;
    send_str("41", 1'b1);
    step();
    check("p41_valid", {7'd0, uio_out[4]}, 8'h01);
    check("p41_byte", uo_out, 8'h41);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("p41_popped_valid", {7'd0, uio_out[4]}, 8'h00);
    check("p41_popped_byte", uo_out, 8'h00);

    // full xxd line
    do_reset();
    out_ready = 1'b1;
    send_str("00000000: 4865 6c6c  Hell\n", 1'b0);
    steps(4);
    exp_q = '{8'h48, 8'h65, 8'h6c, 8'h6c};
    check_seq("line");
    check("line_error", {7'd0, uio_out[7]}, 8'h00);

    // whitespace between nibbles in plain mode
    do_reset();
    send_str("a\nB", 1'b1);
    steps(4);
    exp_q = '{8'hab};
    check_seq("plain_ws");
    check("plain_ws_error", {7'd0, uio_out[7]}, 8'h00);

    // backpressure
    do_reset();
    out_ready = 1'b0;
    send_str("0102030", 1'b1);
    steps(3);
    check("bp_in_ready", {7'd0, uio_out[6]}, 8'h00);
    check("bp_head", uo_out, 8'h01);
    out_ready = 1'b1;
    send_str("405", 1'b1);
    steps(6);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_seq("backpressure");

    // errors
    do_reset();
    send_str(": 4g", 1'b0);
    steps(3);
    check("err_set", {7'd0, uio_out[7]}, 8'h01);
    exp_q.delete();
    check_seq("err_nobyte");
    send_str("\n: 7f", 1'b0);
    steps(4);
    exp_q = '{8'h7f};
    check_seq("err_recover");
    check("err_sticky", {7'd0, uio_out[7]}, 8'h01);
    do_reset();
    check("err_cleared", {7'd0, uio_out[7]}, 8'h00);
    check("err_fifo_empty", {7'd0, uio_out[4]}, 8'h00);

    // reset mid-byte
    send_str("3", 1'b1);
    steps(2);
    do_reset();
    send_str("45", 1'b1);
    steps(4);
    exp_q = '{8'h45};
    check_seq("mid_reset");

    // random phase
    plain = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int r = $urandom_range(0, 15);
      case (r)
        8, 9:    ui_in = 8'h20;
        10:      ui_in = 8'h0A;
        11:      ui_in = 8'h3A;
        12:      ui_in = ($urandom_range(0, 1) == 0) ? 8'h09 : 8'h0D;
        13:      ui_in = ($urandom_range(0, 1) == 0) ? 8'h67 : 8'h7A;
        default: ui_in = hexset[$urandom_range(0, 21)];
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 63) == 0) plain = ~plain;
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    steps(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
